// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter for two requesters driving a single APB master port,
// with misaligned-address rejection and an optional PREADY wait timeout.
module apb_master_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nx;
    logic last, gnt, accept, misalign, timeout, finish;
    logic cap_write, cap_gnt;
    logic [ADDR_W-1:0] cap_addr, gnt_addr;
    logic [DATA_W-1:0] cap_wdata, gnt_wdata;
    logic [31:0] wait_cnt;
    always_comb begin
        // on a tie the requester not served last wins
        gnt       = (&req_valid) ? ~last : req_valid[1];
        gnt_addr  = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        gnt_wdata = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        accept    = (state == IDLE) && (|req_valid);
        misalign  = gnt_addr[1:0] != 2'b00;
        req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        timeout   = (TIMEOUT != 0) && (wait_cnt + 32'd1 == 32'(TIMEOUT));
        finish    = (state == ACCESS) && (PREADY || timeout);
        state_nx  = (state == IDLE)  ? ((accept && !misalign) ? SETUP : IDLE) :
                    (state == SETUP) ? ACCESS :
                    finish           ? IDLE : ACCESS;
        PSEL      = state != IDLE;
        PENABLE   = state == ACCESS;
        PWRITE    = PSEL && cap_write;
        PADDR     = PSEL ? cap_addr : '0;
        PWDATA    = PSEL ? cap_wdata : '0;
    end
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            last      <= 1'b1;
            cap_write <= 1'b0;
            cap_gnt   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wait_cnt  <= (state == ACCESS) ? wait_cnt + 32'd1 : '0;
            if (accept) begin
                cap_write <= req_write[gnt];
                cap_addr  <= gnt_addr;
                cap_wdata <= req_write[gnt] ? gnt_wdata : '0;
                cap_gnt   <= gnt;
                last      <= gnt;
            end
            if (accept && misalign) begin
                rsp_valid <= gnt ? 2'b10 : 2'b01;
                rsp_err   <= 1'b1;
            end
            // a timeout abort reports an error with zero data
            if (finish) begin
                rsp_valid <= cap_gnt ? 2'b10 : 2'b01;
                rsp_err   <= PREADY ? PSLVERR : 1'b1;
                rsp_rdata <= (PREADY && !cap_write) ? PRDATA : '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenario tasks for apb_master_arbiter with hand-computed expectations.
module tb_apb_master_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = 2'b00;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b1;
    logic        PSLVERR = 1'b0;
    int nerr = 0;
    int nchk = 0;

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        nchk++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            nerr++; $display("FAIL reset_ctrl got %b exp 000", {PSEL, PENABLE, PWRITE});
        end
        nchk++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin
            nerr++; $display("FAIL reset_bus got %h/%h exp 0/0", PADDR, PWDATA);
        end
        nchk++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            nerr++; $display("FAIL reset_rsp got %b/%b/%h exp 00/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        req_valid = 2'b11; req_write = 2'b00;
        req_addr  = {32'h0000_003C, 32'h0000_0000};
        PREADY = 1'b1; PRDATA = 32'h0000_0055;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            nchk++;
            if (req_ready !== exp) begin
                nerr++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp);
            end
            if (k > 0) begin
                nchk++;
                if (rsp_valid !== ~exp || rsp_rdata !== 32'h55) begin
                    nerr++; $display("FAIL rr_rsp%0d got %b/%h exp %b/00000055", k, rsp_valid, rsp_rdata, ~exp);
                end
            end
            @(negedge PCLK);
            nchk++;
            if (PADDR !== (exp[1] ? 32'h3C : 32'h0) || PWRITE !== 1'b0) begin
                nerr++; $display("FAIL rr_addr%0d got %h exp %h", k, PADDR, exp[1] ? 32'h3C : 32'h0);
            end
            repeat (2) @(negedge PCLK);
        end
        nchk++;
        if (rsp_valid !== 2'b10) begin
            nerr++; $display("FAIL rr_last_rsp got %b exp 10", rsp_valid);
        end
        req_valid = 2'b00;
        @(negedge PCLK);
    endtask

    task automatic test_write();
        req_valid = 2'b01; req_write = 2'b01;
        req_addr = {32'h0, 32'h0000_0004}; req_wdata = {32'h0, 32'h1000_0000};
        PREADY = 1'b1;
        #1;
        nchk++;
        if (req_ready !== 2'b01 || PSEL !== 1'b0) begin
            nerr++; $display("FAIL wr_accept got %b/%b exp 01/0", req_ready, PSEL);
        end
        @(negedge PCLK);
        req_valid = 2'b00;
        nchk++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h4 || PWDATA !== 32'h1000_0000) begin
            nerr++; $display("FAIL wr_setup got %b %h %h exp 101 4 10000000", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
        end
        @(negedge PCLK);
        nchk++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 32'h4 || PWDATA !== 32'h1000_0000) begin
            nerr++; $display("FAIL wr_access got %b %h %h exp 11 4 10000000", {PSEL, PENABLE}, PADDR, PWDATA);
        end
        @(negedge PCLK);
        nchk++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || PSEL !== 1'b0 || PADDR !== 32'h0) begin
            nerr++; $display("FAIL wr_rsp got %b/%b/%h psel %b paddr %h exp 01/0/0 psel 0 paddr 0", rsp_valid, rsp_err, rsp_rdata, PSEL, PADDR);
        end
        @(negedge PCLK);
        nchk++;
        if (rsp_valid !== 2'b00) begin
            nerr++; $display("FAIL wr_rsp_pulse got %b exp 00", rsp_valid);
        end
    endtask

    task automatic test_wait_states();
        req_valid = 2'b01; req_write = 2'b00;
        req_addr = {32'h0000_0040, 32'h0000_0008};
        #1;
        @(negedge PCLK);
        req_valid = 2'b00; PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge PCLK);
            // non-granted requester toggles during the transfer
            req_valid = (i % 2 == 1) ? 2'b10 : 2'b00;
            #1;
            nchk++;
            if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 32'h8 || req_ready !== 2'b00) begin
                nerr++; $display("FAIL wait_access%0d got %b %h rdy %b exp 11 8 rdy 00", i, {PSEL, PENABLE}, PADDR, req_ready);
            end
            if (i == 4) begin
                req_valid = 2'b00; PREADY = 1'b1; PRDATA = 32'h2000_0000;
            end
        end
        @(negedge PCLK);
        nchk++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h2000_0000 || rsp_err !== 1'b0 || PSEL !== 1'b0) begin
            nerr++; $display("FAIL wait_rsp got %b/%h/%b psel %b exp 01/20000000/0 psel 0", rsp_valid, rsp_rdata, rsp_err, PSEL);
        end
        @(negedge PCLK);
    endtask

    task automatic test_timeout();
        int n;
        req_valid = 2'b10; req_write = 2'b00;
        req_addr = {32'h0000_0010, 32'h0};
        #1;
        @(negedge PCLK);
        req_valid = 2'b00; PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PENABLE !== 1'b1) break;
            n++;
        end
        nchk++;
        if (n !== 16) begin
            nerr++; $display("FAIL timeout_len got %0d exp 16", n);
        end
        nchk++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            nerr++; $display("FAIL timeout_rsp got %b/%b/%h exp 10/1/0", rsp_valid, rsp_err, rsp_rdata);
        end
        PREADY = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_slverr();
        req_valid = 2'b01; req_write = 2'b01;
        req_addr = {32'h0, 32'h0000_0020}; req_wdata = {32'h0, 32'hCAFE_0001};
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h1234_5678;
        #1;
        @(negedge PCLK);
        req_valid = 2'b00;
        repeat (2) @(negedge PCLK);
        nchk++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            nerr++; $display("FAIL slverr_rsp got %b/%b/%h exp 01/1/0", rsp_valid, rsp_err, rsp_rdata);
        end
        PSLVERR = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_misalign();
        req_valid = 2'b10; req_write = 2'b00;
        req_addr = {32'h0000_0006, 32'h0};
        #1;
        nchk++;
        if (req_ready !== 2'b10) begin
            nerr++; $display("FAIL mis_accept got %b exp 10", req_ready);
        end
        @(negedge PCLK);
        req_valid = 2'b00;
        nchk++;
        if (PSEL !== 1'b0 || rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            nerr++; $display("FAIL mis_rsp got psel %b %b/%b/%h exp psel 0 10/1/0", PSEL, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge PCLK);
        nchk++;
        if (PSEL !== 1'b0 || rsp_valid !== 2'b00) begin
            nerr++; $display("FAIL mis_after got psel %b rsp %b exp 0 00", PSEL, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; req_write = 2'b00;
        req_addr = {32'h0000_0030, 32'h0000_000C};
        #1;
        @(negedge PCLK);
        req_valid = 2'b00; PREADY = 1'b0;
        @(negedge PCLK);
        nchk++;
        if (PENABLE !== 1'b1) begin
            nerr++; $display("FAIL rstmid_access got %b exp 1", PENABLE);
        end
        PRESETn = 1'b0;
        @(negedge PCLK);
        nchk++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 2'b00) begin
            nerr++; $display("FAIL rstmid_abort got %b rsp %b exp 00 rsp 00", {PSEL, PENABLE}, rsp_valid);
        end
        PRESETn = 1'b1; PREADY = 1'b1;
        @(negedge PCLK);
        nchk++;
        if (rsp_valid !== 2'b00 || PSEL !== 1'b0) begin
            nerr++; $display("FAIL rstmid_norsp got %b psel %b exp 00 psel 0", rsp_valid, PSEL);
        end
        req_valid = 2'b11;
        #1;
        nchk++;
        if (req_ready !== 2'b01) begin
            nerr++; $display("FAIL rstmid_tie got %b exp 01", req_ready);
        end
        req_valid = 2'b00;
        @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
